zap_fetch_sequencer: RTL and testbench

Fetch-side controller that drives the I-cache request port and feeds the fetch buffer stage. It holds the architectural fetch PC and issues one word-aligned request at a time. It absorbs stalls in a 2-entry response FIFO and steers the PC on redirects from writeback, ALU and decode, discarding stale responses. Its outputs connect directly to the fetch stage's instruction, valid, abort and PC inputs.

---
 rtl/zap_fetch_sequencer.sv | 157 +++++++++++++++
 tb/tb_zap_fetch_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC and issues one word-aligned I-cache request at a time.
// Responses are buffered in a 2-entry FIFO; redirects flush it and discard any stale response.
module zap_fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_code_stall,
   input  logic        i_clear_from_writeback,
   input  logic [31:0] i_pc_from_writeback,
   input  logic        i_clear_from_alu,
   input  logic [31:0] i_pc_from_alu,
   input  logic        i_clear_from_decode,
   input  logic [31:0] i_pc_from_decode,
   input  logic        i_cpsr_t,
   output logic        o_req,
   output logic [31:0] o_addr,
   input  logic        i_ack,
   input  logic [31:0] i_rdata,
   input  logic        i_abort,
   output logic        o_valid,
   output logic [31:0] o_instruction,
   output logic        o_instr_abort,
   output logic [31:0] o_pc_ff
);

   typedef enum logic [1:0] {StIdle, StFetch, StFlush, StHalt} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] fifo_data  [2];
   logic        fifo_abort [2];
   logic [31:0] fifo_pc    [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic [1:0]  count_next;

   logic        redirect;
   logic [31:0] target;
   logic        push;
   logic        pop;
   logic        room;
   logic [31:0] pc_step;

   assign redirect = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;

   always_comb begin
      target = i_pc_from_decode;
      if (i_clear_from_writeback) begin
         target = i_pc_from_writeback;
      end else if (i_clear_from_alu) begin
         target = i_pc_from_alu;
      end
   end

   // Only a live (non-discarded) response in FETCH is buffered.
   assign push    = (state == StFetch) && o_req && i_ack && !redirect;
   assign pop     = (count != 2'd0) && !i_code_stall && !redirect;
   assign pc_step = pc + (i_cpsr_t ? 32'd2 : 32'd4);

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 2'd1;
      end else if (pop && !push) begin
         count_next = count - 2'd1;
      end
   end

   assign room = (count_next <= 2'd1);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= StIdle;
         pc            <= RESET_VECTOR;
         o_req         <= 1'b0;
         o_addr        <= RESET_VECTOR;
         count         <= 2'd0;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         fifo_data[0]  <= '0;
         fifo_data[1]  <= '0;
         fifo_abort[0] <= 1'b0;
         fifo_abort[1] <= 1'b0;
         fifo_pc[0]    <= '0;
         fifo_pc[1]    <= '0;
      end else if (redirect) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         pc     <= target;
         // A request still in flight must be retired before the new target can be issued.
         if (o_req && !i_ack) begin
            state <= StFlush;
         end else begin
            state  <= StFetch;
            o_req  <= 1'b1;
            o_addr <= {target[31:2], 2'b00};
         end
      end else begin
         if (push) begin
            fifo_data[wr_ptr]  <= i_rdata;
            fifo_abort[wr_ptr] <= i_abort;
            fifo_pc[wr_ptr]    <= pc;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count_next;

         unique case (state)
            StIdle: begin
               state  <= StFetch;
               o_req  <= 1'b1;
               o_addr <= {pc[31:2], 2'b00};
            end
            StFetch: begin
               if (o_req) begin
                  if (i_ack) begin
                     pc <= pc_step;
                     if (i_abort) begin
                        state <= StHalt;
                        o_req <= 1'b0;
                     end else if (room) begin
                        o_req  <= 1'b1;
                        o_addr <= {pc_step[31:2], 2'b00};
                     end else begin
                        o_req <= 1'b0;
                     end
                  end
               end else if (room) begin
                  o_req  <= 1'b1;
                  o_addr <= {pc[31:2], 2'b00};
               end
            end
            StFlush: begin
               if (i_ack) begin
                  state  <= StFetch;
                  o_req  <= 1'b1;
                  o_addr <= {pc[31:2], 2'b00};
               end
            end
            StHalt: begin
               o_req <= 1'b0;
            end
         endcase
      end
   end

   assign o_valid       = (count != 2'd0);
   assign o_instruction = o_valid ? fifo_data[rd_ptr] : 32'h0;
   assign o_instr_abort = o_valid ? fifo_abort[rd_ptr] : 1'b0;
   assign o_pc_ff       = o_valid ? fifo_pc[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_zap_fetch_sequencer.sv
// Bench for zap_fetch_sequencer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_zap_fetch_sequencer;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_code_stall;
   logic        i_clear_from_writeback;
   logic [31:0] i_pc_from_writeback;
   logic        i_clear_from_alu;
   logic [31:0] i_pc_from_alu;
   logic        i_clear_from_decode;
   logic [31:0] i_pc_from_decode;
   logic        i_cpsr_t;
   logic        o_req;
   logic [31:0] o_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        i_abort;
   logic        o_valid;
   logic [31:0] o_instruction;
   logic        o_instr_abort;
   logic [31:0] o_pc_ff;

   always #5 i_clk = ~i_clk;

   zap_fetch_sequencer dut (
      .i_clk                  (i_clk),
      .i_reset_n              (i_reset_n),
      .i_code_stall           (i_code_stall),
      .i_clear_from_writeback (i_clear_from_writeback),
      .i_pc_from_writeback    (i_pc_from_writeback),
      .i_clear_from_alu       (i_clear_from_alu),
      .i_pc_from_alu          (i_pc_from_alu),
      .i_clear_from_decode    (i_clear_from_decode),
      .i_pc_from_decode       (i_pc_from_decode),
      .i_cpsr_t               (i_cpsr_t),
      .o_req                  (o_req),
      .o_addr                 (o_addr),
      .i_ack                  (i_ack),
      .i_rdata                (i_rdata),
      .i_abort                (i_abort),
      .o_valid                (o_valid),
      .o_instruction          (o_instruction),
      .o_instr_abort          (o_instr_abort),
      .o_pc_ff                (o_pc_ff)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        abort;
      logic [31:0] pc;
   } ent_t;

   // Reference model: what the fetch stage should see, and what the I-cache port should show.
   ent_t        mq[$];
   logic        m_req;
   logic [31:0] m_addr;
   logic [31:0] m_pc;
   bit          m_flush;
   bit          m_halt;
   bit          m_started;

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] fdata(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_req     = 1'b0;
      m_addr    = 32'h0;
      m_pc      = 32'h0;
      m_flush   = 1'b0;
      m_halt    = 1'b0;
      m_started = 1'b0;
   endtask

   task automatic model_edge();
      logic        redirect;
      logic [31:0] tgt;
      ent_t        e;
      redirect = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;
      tgt = i_clear_from_writeback ? i_pc_from_writeback :
            i_clear_from_alu       ? i_pc_from_alu : i_pc_from_decode;
      if (redirect) begin
         mq.delete();
         m_pc      = tgt;
         m_halt    = 1'b0;
         m_started = 1'b1;
         if (m_req && !i_ack) begin
            m_flush = 1'b1;
         end else begin
            m_flush = 1'b0;
            m_req   = 1'b1;
            m_addr  = align(tgt);
         end
      end else if (!m_started) begin
         m_started = 1'b1;
         m_req     = 1'b1;
         m_addr    = align(m_pc);
      end else begin
         if (mq.size() > 0 && !i_code_stall) void'(mq.pop_front());
         if (m_flush) begin
            if (i_ack) begin
               m_flush = 1'b0;
               m_req   = 1'b1;
               m_addr  = align(m_pc);
            end
         end else if (m_halt) begin
            m_req = 1'b0;
         end else if (m_req && i_ack) begin
            e.data  = fdata(m_addr);
            e.abort = i_abort;
            e.pc    = m_pc;
            mq.push_back(e);
            m_pc = m_pc + (i_cpsr_t ? 32'd2 : 32'd4);
            if (i_abort) begin
               m_halt = 1'b1;
               m_req  = 1'b0;
            end else if (mq.size() <= 1) begin
               m_req  = 1'b1;
               m_addr = align(m_pc);
            end else begin
               m_req = 1'b0;
            end
         end else if (!m_req && mq.size() <= 1) begin
            m_req  = 1'b1;
            m_addr = align(m_pc);
         end
      end
   endtask

   task automatic compare();
      chk("o_req", o_req, m_req);
      chk("o_addr", o_addr, m_addr);
      chk("o_valid", o_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("o_instruction", o_instruction, mq[0].data);
         chk("o_instr_abort", o_instr_abort, mq[0].abort);
         chk("o_pc_ff", o_pc_ff, mq[0].pc);
      end
   endtask

   // One clock: drive at the falling edge, advance the model at the rising edge, compare after.
   task automatic cyc(input bit stall, input bit ack, input bit abort, input bit t,
                      input logic [2:0] clr, input logic [31:0] pw, input logic [31:0] pa,
                      input logic [31:0] pd);
      i_code_stall           = stall;
      i_ack                  = ack && m_req;
      i_abort                = abort && i_ack;
      i_rdata                = i_ack ? fdata(m_addr) : 32'hBAD0_0000;
      i_cpsr_t               = t;
      i_clear_from_writeback = clr[2];
      i_clear_from_alu       = clr[1];
      i_clear_from_decode    = clr[0];
      i_pc_from_writeback    = pw;
      i_pc_from_alu          = pa;
      i_pc_from_decode       = pd;
      @(posedge i_clk);
      model_edge();
      @(negedge i_clk);
      compare();
   endtask

   task automatic run(input bit ack);
      cyc(1'b0, ack, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic run_t(input bit ack);
      cyc(1'b0, ack, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      i_reset_n              = 1'b0;
      i_code_stall           = 1'b0;
      i_clear_from_writeback = 1'b0;
      i_clear_from_alu       = 1'b0;
      i_clear_from_decode    = 1'b0;
      i_pc_from_writeback    = 32'h0;
      i_pc_from_alu          = 32'h0;
      i_pc_from_decode       = 32'h0;
      i_cpsr_t               = 1'b0;
      i_ack                  = 1'b0;
      i_rdata                = 32'h0;
      i_abort                = 1'b0;
      model_reset();

      repeat (2) @(negedge i_clk);
      chk("rst_req", o_req, 1'b0);
      chk("rst_addr", o_addr, 32'h0);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_instr", o_instruction, 32'h0);
      chk("rst_abort", o_instr_abort, 1'b0);
      chk("rst_pc_ff", o_pc_ff, 32'h0);
      i_reset_n = 1'b1;

      // Streaming ARM fetch from reset.
      run(1'b0);
      chk("s1_req", o_req, 1'b1);
      chk("s1_addr0", o_addr, 32'h0);
      run(1'b1);
      chk("s1_addr4", o_addr, 32'h4);
      chk("s1_pc0", o_pc_ff, 32'h0);
      run(1'b1);
      chk("s1_addr8", o_addr, 32'h8);
      chk("s1_pc4", o_pc_ff, 32'h4);
      run(1'b1);
      chk("s1_addr12", o_addr, 32'hC);
      chk("s1_pc8", o_pc_ff, 32'h8);

      // Stall: FIFO fills to two and the request drops.
      repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      chk("s2_req_low", o_req, 1'b0);
      chk("s2_pc_held", o_pc_ff, 32'h8);
      run(1'b1);
      chk("s2_req_back", o_req, 1'b1);
      chk("s2_addr16", o_addr, 32'h10);
      chk("s2_pc12", o_pc_ff, 32'hC);
      run(1'b1);
      chk("s2_pc16", o_pc_ff, 32'h10);

      // Redirect while the request is outstanding; stale data is dropped.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h0, 32'h0, 32'h10);
      chk("s3_addr10", o_addr, 32'h10);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h100, 32'h0);
      chk("s3_addr_held", o_addr, 32'h10);
      run(1'b0);
      run(1'b0);
      run(1'b1);
      chk("s3_addr100", o_addr, 32'h100);
      chk("s3_empty", o_valid, 1'b0);
      run(1'b1);
      chk("s3_pc100", o_pc_ff, 32'h100);
      chk("s3_data", o_instruction, 32'hDEAD_BFEF);

      // Simultaneous redirects: writeback wins.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 32'h200, 32'h300, 32'h400);
      chk("s4_addr200", o_addr, 32'h200);
      chk("s4_empty", o_valid, 1'b0);

      // Instruction abort halts fetch until a redirect.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 32'h20, 32'h0, 32'h0);
      chk("s5_addr20", o_addr, 32'h20);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
      chk("s5_abort", o_instr_abort, 1'b1);
      chk("s5_abort_pc", o_pc_ff, 32'h20);
      chk("s5_req_low", o_req, 1'b0);
      repeat (10) run(1'b1);
      chk("s5_still_halt", o_req, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 32'h18, 32'h0, 32'h0);
      chk("s5_resume_req", o_req, 1'b1);
      chk("s5_resume_addr", o_addr, 32'h18);
      run(1'b1);
      chk("s5_pc18", o_pc_ff, 32'h18);

      // Thumb stepping fetches each word twice.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 32'h1000, 32'h0, 32'h0);
      chk("s6_addr_a", o_addr, 32'h1000);
      run_t(1'b1);
      chk("s6_addr_b", o_addr, 32'h1000);
      chk("s6_pc_a", o_pc_ff, 32'h1000);
      run_t(1'b1);
      chk("s6_addr_c", o_addr, 32'h1004);
      chk("s6_pc_b", o_pc_ff, 32'h1002);
      run_t(1'b1);
      chk("s6_pc_c", o_pc_ff, 32'h1004);

      // PC wraps at the top of the address space.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFC, 32'h0, 32'h0);
      chk("s7_addr_top", o_addr, 32'hFFFF_FFFC);
      run(1'b1);
      chk("s7_addr_wrap", o_addr, 32'h0);
      chk("s7_pc_top", o_pc_ff, 32'hFFFF_FFFC);
      run(1'b1);
      chk("s7_pc_wrap", o_pc_ff, 32'h0);

      // Mixed traffic, checked by the model every cycle.
      for (int i = 0; i < 300; i++) begin
         int unsigned r;
         logic [2:0]  clr;
         r = $urandom_range(0, 15);
         clr = (r == 0) ? 3'b100 : (r == 1) ? 3'b010 : (r == 2) ? 3'b001 :
               (r == 3) ? 3'b111 : 3'b000;
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), clr,
             $urandom, $urandom, $urandom);
      end

      // Reset asserted together with a redirect: reset wins.
      i_clear_from_writeback = 1'b1;
      i_pc_from_writeback    = 32'h500;
      i_reset_n              = 1'b0;
      #1;
      chk("rst2_req", o_req, 1'b0);
      chk("rst2_addr", o_addr, 32'h0);
      chk("rst2_valid", o_valid, 1'b0);
      @(negedge i_clk);
      chk("rst2_addr_hold", o_addr, 32'h0);
      chk("rst2_req_hold", o_req, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
